fast_scan_ctrl: RTL

- Raster-scan sequencer at the front of the FAST corner pipeline.
- Accepts the pixel stream from the ARM DMA under a valid/ready handshake and tracks column/row.
- Drives the write side of the (FAST_PATCH_SIZE-1)-line ring buffer.
- Flags each accepted pixel that completes a full FAST_PATCH_SIZE x FAST_PATCH_SIZE window and reports that window's centre coordinate to the detector/NMS stages.

---
 rtl/fast_scan_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fast_scan_ctrl.sv
// fast_scan_ctrl: raster-scan sequencer for the FAST corner front end.
// Tracks col/row, drives line-buffer writes and flags completed windows.
`timescale 1ns/1ps
module fast_scan_ctrl #(
  parameter int COL_NUM         = 640,
  parameter int ROW_NUM         = 480,
  parameter int FAST_PATCH_SIZE = 7,
  parameter int PIXEL_WIDTH     = 8,
  localparam int R   = FAST_PATCH_SIZE / 2,
  localparam int NLB = FAST_PATCH_SIZE - 1,
  localparam int CW  = $clog2(COL_NUM),
  localparam int RW  = $clog2(ROW_NUM),
  localparam int LW  = $clog2(NLB)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           frame_start,
  input  logic           s_valid,
  output logic           s_ready,
  output logic           lb_wr_en,
  output logic [CW-1:0]  lb_wr_addr,
  output logic [NLB-1:0] lb_wr_sel,
  output logic [LW-1:0]  lb_rd_base,
  output logic           win_valid,
  input  logic           m_ready,
  output logic [CW-1:0]  center_x,
  output logic [RW-1:0]  center_y,
  output logic           frame_done,
  output logic           busy
);

  if (PIXEL_WIDTH < 1 || FAST_PATCH_SIZE < 3 ||
      FAST_PATCH_SIZE % 2 == 0) begin : g_bad_cfg
    $error("fast_scan_ctrl: bad parameters");
  end

  localparam logic [CW-1:0] C_LAST = CW'(COL_NUM - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROW_NUM - 1);
  localparam logic [RW-1:0] R_FILL = RW'(NLB - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(2 * R);
  localparam logic [RW-1:0] R_MIN  = RW'(2 * R);
  localparam logic [CW-1:0] C_OFF  = CW'(R);
  localparam logic [RW-1:0] R_OFF  = RW'(R);
  localparam logic [LW-1:0] B_LAST = LW'(NLB - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic accept;
  logic col_wrap;
  logic start;
  logic win_set;
  logic win_pop;

  assign s_ready  = ce & ((state == FILL) | (state == RUN))
                  & (~win_valid | m_ready);
  assign accept   = s_valid & s_ready;
  assign col_wrap = accept & (col == C_LAST);
  assign start    = ce & frame_start & (state == IDLE);
  assign win_set  = accept & (col >= C_MIN) & (row >= R_MIN);
  assign win_pop  = ce & win_valid & m_ready;

  assign lb_wr_en   = accept;
  assign lb_wr_addr = col;
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: if (col_wrap && row == R_FILL) state_nxt = RUN;
      RUN:  if (col_wrap && row == R_LAST) state_nxt = DONE;
      DONE: if (ce) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // sel/base restart with the frame so row 0 always lands in buffer 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      lb_wr_sel  <= NLB'(1);
      lb_rd_base <= '0;
    end else if (start) begin
      col        <= '0;
      row        <= '0;
      lb_wr_sel  <= NLB'(1);
      lb_rd_base <= '0;
    end else if (accept) begin
      if (col == C_LAST) begin
        col       <= '0;
        row       <= row + RW'(1);
        lb_wr_sel <= {lb_wr_sel[NLB-2:0], lb_wr_sel[NLB-1]};
        if (row >= R_FILL)
          lb_rd_base <= (lb_rd_base == B_LAST) ? '0
                      : lb_rd_base + LW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid <= 1'b0;
      center_x  <= '0;
      center_y  <= '0;
    end else if (win_set) begin
      win_valid <= 1'b1;
      center_x  <= col - C_OFF;
      center_y  <= row - R_OFF;
    end else if (win_pop) begin
      win_valid <= 1'b0;
    end
  end

endmodule
